// File: rtl/j11uart_pkg.sv
// Shared register offsets, CSR bit positions and FSM encodings for the console line unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package j11uart_pkg;

    // byte offsets of the four registers within the block
    localparam logic [2:0] REG_RCSR = 3'd0;
    localparam logic [2:0] REG_RBUF = 3'd2;
    localparam logic [2:0] REG_XCSR = 3'd4;
    localparam logic [2:0] REG_XBUF = 3'd6;

    // receiver status / buffer bit positions
    localparam int BIT_DONE  = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_BUSY  = 11;
    localparam int BIT_ERR   = 15;
    localparam int BIT_OVR   = 14;
    localparam int BIT_FRM   = 13;

    // transmitter status bit positions
    localparam int BIT_READY = 7;
    localparam int BIT_MAINT = 2;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/j11uart_if.sv
// Register port between the memory arbiter and the console line unit.
// Latency: uartack follows uartreq by exactly one clock.
// Backpressure: none; the requester keeps at most one access outstanding.
interface j11uart_if;
    logic        uartreq;
    logic [2:0]  uartaddr;
    logic        uartwr;
    logic [15:0] uartwdata;
    logic        uartack;
    logic [15:0] uartrdata;

    modport master (
        output uartreq, uartaddr, uartwr, uartwdata,
        input  uartack, uartrdata
    );

    modport slave (
        input  uartreq, uartaddr, uartwr, uartwdata,
        output uartack, uartrdata
    );
endinterface

// File: rtl/j11uart_rx.sv
// 8N1 serial receiver: synchroniser, start/glitch filter, LSB-first shifter, stop check.
// Latency: completion strobe in the cycle the stop bit is sampled (mid stop bit).
// Backpressure: none; the register file must absorb each strobe (overrun is flagged there).
module j11uart_rx
    import j11uart_pkg::*;
#(
    parameter int CLKDIV = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    input  logic       loop_en,
    input  logic       loop_txd,
    output logic       busy,
    output logic       done_stb,
    output logic [7:0] data,
    output logic       frm_err
);

    localparam int            CW   = $clog2(CLKDIV);
    localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          rxd_m;
    logic          rxd_s;
    logic          line;
    logic          line_q;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bitn;
    logic [2:0]    bitn_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;

    // loopback taps the already-registered txd, so it bypasses the synchroniser
    assign line = loop_en ? loop_txd : rxd_s;

    // two-flop synchroniser and previous line value for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            line_q <= 1'b1;
        end else begin
            rxd_m  <= rxd;
            rxd_s  <= rxd_m;
            line_q <= line;
        end
    end

    // receiver state, baud counter, bit counter and shift register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RX_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bitn  <= bitn_nxt;
            shift <= shift_nxt;
        end
    end

    // next state: half-bit start qualification, then full-bit sampling
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bitn_nxt  = bitn;
        shift_nxt = shift;
        done_stb  = 1'b0;
        frm_err   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (line_q && !line) begin
                    state_nxt = RX_START;
                    cnt_nxt   = HALF;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (line) begin
                        state_nxt = RX_IDLE;
                    end else begin
                        state_nxt = RX_DATA;
                        cnt_nxt   = FULL;
                        bitn_nxt  = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {line, shift[7:1]};
                    bitn_nxt  = bitn + 3'd1;
                    cnt_nxt   = FULL;
                    if (bitn == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_nxt = RX_IDLE;
                    done_stb  = 1'b1;
                    frm_err   = !line;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign busy = (state != RX_IDLE);
    assign data = shift;

endmodule

// File: rtl/j11uart.sv
// DL11-style console line: RCSR/RBUF/XCSR/XBUF registers, 8N1 tx shifter, rx sub-block, level irqs.
// Latency: register access acks one clock after request; tx line moves one clock after XBUF load.
// Backpressure: XBUF writes while READY=0 are dropped; rx overrun is flagged, not stalled.
module j11uart
    import j11uart_pkg::*;
#(
    parameter int CLKDIV = 434
) (
    input  logic     clk,
    input  logic     rstn,
    j11uart_if.slave bus,
    input  logic     rxd,
    output logic     txd,
    output logic     rxirq,
    output logic     txirq
);

    localparam int            CW   = $clog2(CLKDIV);
    localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    // register file
    logic       rdone;
    logic       rie;
    logic       rovr;
    logic       rfrm;
    logic [7:0] rdata;
    logic       xready;
    logic       xie;
    logic       maint;
    logic [7:0] xhold;

    // bus decode
    logic [2:0]  reg_sel;
    logic        rd_req;
    logic        wr_req;
    logic        rbuf_rd;
    logic [15:0] rd_mux;
    logic        unused_bits;

    // rx sub-block outputs
    logic       rx_busy;
    logic       rx_stb;
    logic [7:0] rx_data;
    logic       rx_frm;

    // tx shifter
    tx_state_t     tx_state;
    tx_state_t     tx_state_nxt;
    logic [CW-1:0] tcnt;
    logic [CW-1:0] tcnt_nxt;
    logic [2:0]    tbit;
    logic [2:0]    tbit_nxt;
    logic [7:0]    tsh;
    logic [7:0]    tsh_nxt;
    logic          tx_load;
    logic          txd_nxt;

    assign reg_sel     = {bus.uartaddr[2:1], 1'b0};
    assign rd_req      = bus.uartreq && !bus.uartwr;
    assign wr_req      = bus.uartreq && bus.uartwr;
    assign rbuf_rd     = rd_req && (reg_sel == REG_RBUF);
    assign unused_bits = ^{bus.uartaddr[0], bus.uartwdata[15:8]};

    j11uart_rx #(
        .CLKDIV (CLKDIV)
    ) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .loop_en  (maint),
        .loop_txd (txd),
        .busy     (rx_busy),
        .done_stb (rx_stb),
        .data     (rx_data),
        .frm_err  (rx_frm)
    );

    // read data selection from current (pre-edge) register contents
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_RCSR: begin
                rd_mux[BIT_DONE] = rdone;
                rd_mux[BIT_IE]   = rie;
                rd_mux[BIT_BUSY] = rx_busy;
                rd_mux[BIT_ERR]  = rovr | rfrm;
            end
            REG_RBUF: begin
                rd_mux[7:0]     = rdata;
                rd_mux[BIT_FRM] = rfrm;
                rd_mux[BIT_OVR] = rovr;
                rd_mux[BIT_ERR] = rovr | rfrm;
            end
            REG_XCSR: begin
                rd_mux[BIT_READY] = xready;
                rd_mux[BIT_IE]    = xie;
                rd_mux[BIT_MAINT] = maint;
            end
            default: rd_mux = '0;
        endcase
    end

    // one-cycle ack; read data held until the next read
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.uartack   <= 1'b0;
            bus.uartrdata <= '0;
        end else begin
            bus.uartack <= bus.uartreq;
            if (rd_req) begin
                bus.uartrdata <= rd_mux;
            end
        end
    end

    // writable control bits in RCSR and XCSR
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rie   <= 1'b0;
            xie   <= 1'b0;
            maint <= 1'b0;
        end else if (wr_req) begin
            if (reg_sel == REG_RCSR) begin
                rie <= bus.uartwdata[BIT_IE];
            end
            if (reg_sel == REG_XCSR) begin
                xie   <= bus.uartwdata[BIT_IE];
                maint <= bus.uartwdata[BIT_MAINT];
            end
        end
    end

    // receive buffer: a completion coinciding with an RBUF read takes priority
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdone <= 1'b0;
            rovr  <= 1'b0;
            rfrm  <= 1'b0;
            rdata <= '0;
        end else if (rx_stb) begin
            rdata <= rx_data;
            rdone <= 1'b1;
            if (rbuf_rd) begin
                rovr <= 1'b0;
                rfrm <= rx_frm;
            end else begin
                rovr <= rovr | rdone;
                rfrm <= rfrm | rx_frm;
            end
        end else if (rbuf_rd) begin
            rdone <= 1'b0;
            rovr  <= 1'b0;
            rfrm  <= 1'b0;
        end
    end

    // holding register: accepted only while READY, freed when the shifter takes it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            xready <= 1'b1;
            xhold  <= '0;
        end else if (wr_req && (reg_sel == REG_XBUF) && xready) begin
            xhold  <= bus.uartwdata[7:0];
            xready <= 1'b0;
        end else if (tx_load) begin
            xready <= 1'b1;
        end
    end

    // tx shifter state, counters and registered line output
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tcnt     <= '0;
            tbit     <= '0;
            tsh      <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tcnt     <= tcnt_nxt;
            tbit     <= tbit_nxt;
            tsh      <= tsh_nxt;
            txd      <= txd_nxt;
        end
    end

    // tx sequencing: start, 8 data LSB first, stop; reload from holding with no gap
    always_comb begin
        tx_state_nxt = tx_state;
        tcnt_nxt     = tcnt;
        tbit_nxt     = tbit;
        tsh_nxt      = tsh;
        tx_load      = 1'b0;
        txd_nxt      = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!xready) begin
                    tx_load      = 1'b1;
                    tx_state_nxt = TX_START;
                    tcnt_nxt     = FULL;
                    tsh_nxt      = xhold;
                end
            end
            TX_START: begin
                if (tcnt == '0) begin
                    tx_state_nxt = TX_DATA;
                    tcnt_nxt     = FULL;
                    tbit_nxt     = 3'd0;
                end else begin
                    tcnt_nxt = tcnt - ONE;
                end
            end
            TX_DATA: begin
                if (tcnt == '0) begin
                    tcnt_nxt = FULL;
                    tbit_nxt = tbit + 3'd1;
                    tsh_nxt  = {1'b0, tsh[7:1]};
                    if (tbit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end
                end else begin
                    tcnt_nxt = tcnt - ONE;
                end
            end
            TX_STOP: begin
                if (tcnt == '0) begin
                    if (!xready) begin
                        tx_load      = 1'b1;
                        tx_state_nxt = TX_START;
                        tcnt_nxt     = FULL;
                        tsh_nxt      = xhold;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    tcnt_nxt = tcnt - ONE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START: txd_nxt = 1'b0;
            TX_DATA:  txd_nxt = tsh_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    // level interrupt requests, registered one cycle behind their sources
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxirq <= 1'b0;
            txirq <= 1'b0;
        end else begin
            rxirq <= rie & rdone;
            txirq <= xie & xready;
        end
    end

endmodule

// File: tb/tb_j11uart.sv
// Scoreboard bench for the console line unit at CLKDIV=8.
// Latency: checks ack one clock after each request and exact tx waveforms.
// Backpressure: exercises dropped XBUF writes and rx overrun.
module tb_j11uart;
    import j11uart_pkg::*;

    localparam int CLKDIV = 8;

    logic clk;
    logic rstn;
    logic rxd;
    logic txd;
    logic rxirq;
    logic txirq;

    j11uart_if bus ();

    j11uart #(
        .CLKDIV (CLKDIV)
    ) u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .rxd   (rxd),
        .txd   (txd),
        .rxirq (rxirq),
        .txirq (txirq)
    );

    int total = 0;
    int bad   = 0;
    int tx_frames = 0;
    logic txmon_en;

    logic [15:0] last_rd;
    logic [15:0] exp_rd[$];
    string       exp_tag[$];
    logic [7:0]  exp_tx[$];

    logic [79:0] mon_got;
    logic [79:0] mon_exp;
    logic [7:0]  mon_byte;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // drive a request and record what its ack must carry
    task automatic start(input logic w, input logic [2:0] a, input logic [15:0] d,
                         input logic [15:0] e, input string tag);
        bus.uartreq   = 1'b1;
        bus.uartwr    = w;
        bus.uartaddr  = a;
        bus.uartwdata = d;
        if (!w) last_rd = e;
        exp_rd.push_back(last_rd);
        exp_tag.push_back(tag);
    endtask

    // compare the ack that has just arrived against the oldest expectation
    task automatic retire();
        string       t;
        logic [15:0] e;
        t = exp_tag.pop_front();
        e = exp_rd.pop_front();
        chk({t, "_ack"}, bus.uartack, 1'b1);
        chk(t, bus.uartrdata, e);
    endtask

    task automatic acc(input logic w, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] e, input string tag);
        start(w, a, d, e, tag);
        @(negedge clk);
        bus.uartreq = 1'b0;
        retire();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CLKDIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CLKDIV) @(negedge clk);
        end
        rxd = stop;
        repeat (CLKDIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    // tx monitor: capture 80 samples from each start bit and compare cycle by cycle
    initial begin
        forever begin
            @(negedge clk);
            if (txmon_en && txd === 1'b0) begin
                mon_got    = '0;
                mon_got[0] = 1'b0;
                for (int i = 1; i < 80; i++) begin
                    @(negedge clk);
                    mon_got[i] = txd;
                end
                chk("tx_q_nonempty", 80'(exp_tx.size() != 0), 80'd1);
                mon_byte = exp_tx.pop_front();
                for (int i = 0; i < 80; i++) begin
                    if (i < 8)        mon_exp[i] = 1'b0;
                    else if (i >= 72) mon_exp[i] = 1'b1;
                    else              mon_exp[i] = mon_byte[(i - 8) / 8];
                end
                chk("tx_wave", mon_got, mon_exp);
                tx_frames++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.uartreq   = 1'b0;
        bus.uartwr    = 1'b0;
        bus.uartaddr  = '0;
        bus.uartwdata = '0;
        rxd      = 1'b1;
        rstn     = 1'b0;
        txmon_en = 1'b1;
        last_rd  = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_ack", bus.uartack, 1'b0);
        chk("rst_rdata", bus.uartrdata, 16'd0);
        chk("rst_rxirq", rxirq, 1'b0);
        chk("rst_txirq", txirq, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // reset register contents
        acc(1'b0, REG_RCSR, 16'd0, 16'o000000, "rd_rcsr");
        @(negedge clk);
        chk("ack_drop", bus.uartack, 1'b0);
        acc(1'b0, REG_RBUF, 16'd0, 16'o000000, "rd_rbuf");
        acc(1'b0, REG_XCSR, 16'd0, 16'o000200, "rd_xcsr");
        acc(1'b0, REG_XBUF, 16'd0, 16'o000000, "rd_xbuf");
        acc(1'b0, 3'd5,     16'd0, 16'o000200, "rd_xcsr_odd");

        // transmit 0o101; a read issued back to back sees READY still clear
        exp_tx.push_back(8'o101);
        start(1'b1, REG_XBUF, 16'o101, 16'd0, "wr_xbuf");
        @(negedge clk);
        start(1'b0, REG_XCSR, 16'd0, 16'o000000, "xcsr_busy");
        retire();
        @(negedge clk);
        bus.uartreq = 1'b0;
        retire();
        acc(1'b0, REG_XCSR, 16'd0, 16'o000200, "xcsr_ready");
        repeat (90) @(negedge clk);

        acc(1'b1, REG_XCSR, 16'o000100, 16'd0, "wr_xie");
        @(negedge clk);
        chk("txirq_on", txirq, 1'b1);
        acc(1'b0, REG_XCSR, 16'd0, 16'o000300, "xcsr_ie");
        acc(1'b1, REG_XCSR, 16'o000000, 16'd0, "wr_xie0");
        @(negedge clk);
        chk("txirq_off", txirq, 1'b0);

        // receive 0x5A
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        acc(1'b0, REG_RCSR, 16'd0, 16'o000200, "rcsr_done");
        acc(1'b0, REG_RBUF, 16'd0, 16'o000132, "rbuf_5a");
        acc(1'b0, REG_RCSR, 16'd0, 16'o000000, "rcsr_clr");

        // receive interrupt follows DONE
        acc(1'b1, REG_RCSR, 16'o000100, 16'd0, "wr_rie");
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        chk("rxirq_on", rxirq, 1'b1);
        acc(1'b0, REG_RBUF, 16'd0, 16'o000132, "rbuf_5a_irq");
        @(negedge clk);
        chk("rxirq_off", rxirq, 1'b0);
        acc(1'b1, REG_RCSR, 16'o000000, 16'd0, "wr_rie0");

        // overrun then framing error, sticky until RBUF read
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        acc(1'b0, REG_RCSR, 16'd0, 16'o100200, "rcsr_ovr");
        send_frame(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        acc(1'b0, REG_RCSR, 16'd0, 16'o100200, "rcsr_frm");
        acc(1'b0, REG_RBUF, 16'd0, 16'o160042, "rbuf_err");
        acc(1'b0, REG_RCSR, 16'd0, 16'o000000, "rcsr_err_clr");
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        acc(1'b0, REG_RBUF, 16'd0, 16'o000042, "rbuf_clean");

        // loopback; second back-to-back XBUF write is dropped
        acc(1'b1, REG_XCSR, 16'o000004, 16'd0, "wr_maint");
        rxd = 1'b0;
        exp_tx.push_back(8'hC3);
        start(1'b1, REG_XBUF, 16'h00C3, 16'd0, "wr_c3_a");
        @(negedge clk);
        start(1'b1, REG_XBUF, 16'h00C3, 16'd0, "wr_c3_b");
        retire();
        @(negedge clk);
        bus.uartreq = 1'b0;
        retire();
        acc(1'b0, REG_XCSR, 16'd0, 16'o000204, "xcsr_maint");
        repeat (100) @(negedge clk);
        chk("tx_q_empty", exp_tx.size(), 0);
        acc(1'b0, REG_RCSR, 16'd0, 16'o000200, "rcsr_loop");
        acc(1'b0, REG_RBUF, 16'd0, 16'o000303, "rbuf_loop");
        rxd = 1'b1;
        @(negedge clk);
        acc(1'b1, REG_XCSR, 16'o000000, 16'd0, "wr_maint0");

        // reset in the middle of a tx frame and an rx frame
        txmon_en = 1'b0;
        acc(1'b1, REG_XBUF, 16'h0000, 16'd0, "wr_x00_a");
        repeat (2) @(negedge clk);
        acc(1'b1, REG_XBUF, 16'h0000, 16'd0, "wr_x00_b");
        fork
            send_frame(8'hFF, 1'b1);
        join_none
        repeat (30) @(negedge clk);
        acc(1'b0, REG_RCSR, 16'd0, 16'o004000, "rcsr_busy");
        acc(1'b0, REG_XCSR, 16'd0, 16'o000000, "xcsr_full");
        chk("tx_mid", txd, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst2_txd", txd, 1'b1);
        chk("rst2_rdata", bus.uartrdata, 16'd0);
        rstn = 1'b1;
        last_rd = '0;
        acc(1'b0, REG_XCSR, 16'd0, 16'o000200, "rst2_xcsr");
        acc(1'b0, REG_RCSR, 16'd0, 16'o000000, "rst2_rcsr");
        repeat (80) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        acc(1'b0, REG_RCSR, 16'd0, 16'o000200, "rcsr_after_rst");
        acc(1'b0, REG_RBUF, 16'd0, 16'o000245, "rbuf_after_rst");
        txmon_en = 1'b1;
        repeat (10) @(negedge clk);

        chk("tx_frames", tx_frames, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
